// File: rtl/vjtag_debug_host.sv
// Virtual-JTAG scan initiator: one command -> UIR, CDR, SDR x DR_WIDTH, UDR, RTI, then response.
// Optional macro VJTAG_DEBUG_HOST_IR_CACHE_EN skips the UIR slot when the IR is unchanged.
module vjtag_debug_host #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [IR_WIDTH-1:0] cmd_ir_i,
  input  logic [DR_WIDTH-1:0] cmd_data_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DR_WIDTH-1:0] rsp_data_o,
  output logic [IR_WIDTH-1:0] rsp_ir_o,
  output logic                tck_o,
  output logic                tdi_o,
  input  logic                tdo_i,
  output logic [IR_WIDTH-1:0] ir_in_o,
  input  logic [IR_WIDTH-1:0] ir_out_i,
  output logic                vs_uir_o,
  output logic                vs_cdr_o,
  output logic                vs_sdr_o,
  output logic                vs_udr_o,
  output logic                jtag_state_rti_o
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
  localparam int BW = $clog2(DR_WIDTH + 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(2 * TCK_DIV - 1);
  localparam logic [CW-1:0] RISE_AT   = CW'(TCK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DR_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RSP} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DR_WIDTH-1:0] shift_q, shift_d;
  logic [IR_WIDTH-1:0] ir_lat_q, ir_lat_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic                tck_q, tck_d;
  logic                tdi_q, tdi_d;
  logic                uir_q, uir_d, cdr_q, cdr_d, sdr_q, sdr_d, udr_q, udr_d, rti_q, rti_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
  logic                slot_end, rise, scanning;
`ifdef VJTAG_DEBUG_HOST_IR_CACHE_EN
  logic                cvld_q, cvld_d;
  logic                skip_q, skip_d;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      ir_lat_q    <= '0;
      ir_in_q     <= '0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ir_q    <= '0;
`ifdef VJTAG_DEBUG_HOST_IR_CACHE_EN
      cvld_q      <= 1'b0;
      skip_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      ir_lat_q    <= ir_lat_d;
      ir_in_q     <= ir_in_d;
      tck_q       <= tck_d;
      tdi_q       <= tdi_d;
      uir_q       <= uir_d;
      cdr_q       <= cdr_d;
      sdr_q       <= sdr_d;
      udr_q       <= udr_d;
      rti_q       <= rti_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ir_q    <= rsp_ir_d;
`ifdef VJTAG_DEBUG_HOST_IR_CACHE_EN
      cvld_q      <= cvld_d;
      skip_q      <= skip_d;
`endif
    end
  end

  // All pin-level outputs are registered from their next-state value, so
  // strobes/tdi/ir_in can only move on the edge that starts a slot (cnt -> 0).
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    bit_d       = bit_q;
    shift_d     = shift_q;
    ir_lat_d    = ir_lat_q;
    ir_in_d     = ir_in_q;
    tck_d       = 1'b0;
    tdi_d       = tdi_q;
    uir_d       = uir_q;
    cdr_d       = cdr_q;
    sdr_d       = sdr_q;
    udr_d       = udr_q;
    rti_d       = rti_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_ir_d    = rsp_ir_q;
`ifdef VJTAG_DEBUG_HOST_IR_CACHE_EN
    cvld_d      = cvld_q;
    skip_d      = skip_q;
`endif
    slot_end = (cnt_q == SLOT_LAST);
    rise     = (cnt_q == RISE_AT);
    scanning = (state_q != IDLE) && (state_q != RSP);

    if (scanning) begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
      tck_d = !slot_end && (cnt_q >= RISE_AT);
    end

    case (state_q)
      IDLE: begin
        if (cmd_ready_q) begin
          if (cmd_valid_i) begin
            ir_lat_d    = cmd_ir_i;
            shift_d     = cmd_data_i;
            cmd_ready_d = 1'b0;
          end
        end else begin
          // one cycle after accept: first slot starts with cnt=0
`ifdef VJTAG_DEBUG_HOST_IR_CACHE_EN
          if (cvld_q && (ir_lat_q == ir_in_q)) begin
            state_d = CDR;
            cdr_d   = 1'b1;
            skip_d  = 1'b1;
          end else begin
            state_d = UIR;
            uir_d   = 1'b1;
            ir_in_d = ir_lat_q;
            cvld_d  = 1'b1;
            skip_d  = 1'b0;
          end
`else
          state_d = UIR;
          uir_d   = 1'b1;
          ir_in_d = ir_lat_q;
`endif
        end
      end
      UIR: begin
        if (rise) rsp_ir_d = ir_out_i;
        if (slot_end) begin
          uir_d   = 1'b0;
          cdr_d   = 1'b1;
          state_d = CDR;
        end
      end
      CDR: begin
`ifdef VJTAG_DEBUG_HOST_IR_CACHE_EN
        if (rise && skip_q) rsp_ir_d = ir_out_i;
`endif
        if (slot_end) begin
          cdr_d   = 1'b0;
          sdr_d   = 1'b1;
          tdi_d   = shift_q[0];
          bit_d   = '0;
          state_d = SDR;
        end
      end
      SDR: begin
        if (rise) shift_d = {tdo_i, shift_q[DR_WIDTH-1:1]};
        if (slot_end) begin
          if (bit_q == BIT_LAST) begin
            sdr_d   = 1'b0;
            udr_d   = 1'b1;
            tdi_d   = 1'b0;
            state_d = UDR;
          end else begin
            bit_d = bit_q + 1'b1;
            tdi_d = shift_q[0];
          end
        end
      end
      UDR: begin
        if (slot_end) begin
          udr_d   = 1'b0;
          rti_d   = 1'b1;
          state_d = RTI;
        end
      end
      RTI: begin
        if (slot_end) begin
          rti_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = shift_q;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready_o      = cmd_ready_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_data_o       = rsp_data_q;
  assign rsp_ir_o         = rsp_ir_q;
  assign tck_o            = tck_q;
  assign tdi_o            = tdi_q;
  assign ir_in_o          = ir_in_q;
  assign vs_uir_o         = uir_q;
  assign vs_cdr_o         = cdr_q;
  assign vs_sdr_o         = sdr_q;
  assign vs_udr_o         = udr_q;
  assign jtag_state_rti_o = rti_q;

endmodule
